cnn_mem_arb: RTL and testbench

Two-port arbiter and sequencer in front of the single-port CNN weight/activation memory.
- Shares the memory between the HPS host bus (loads weights and images, reads results) and the CNN compute engine (streams weights and activations).
- Issues at most one memory access per cycle and returns read data to the correct requester.
- Engine burst locks are bounded so the host is never starved.

---
 rtl/cnn_mem_arb.sv | 158 +++++++++++++++
 tb/tb_cnn_mem_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_mem_arb.sv
// rtl/cnn_mem_arb.sv - host/engine arbiter and sequencer for the single-port CNN memory
// Optional CNN_ARB_PERF_EN adds saturating grant/stall counters.
module cnn_mem_arb #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 375000,
  parameter int LOCK_MAX  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h_chipselect,
  input  logic              h_read,
  input  logic              h_write,
  input  logic [ADDR_W-1:0] h_address,
  input  logic [DATA_W-1:0] h_writedata,
  output logic              h_waitrequest,
  output logic              h_readdatavalid,
  output logic [DATA_W-1:0] h_readdata,
  input  logic              e_req,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  input  logic              e_lock,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  output logic              err_oor,
  output logic              m_chipselect,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata
`ifdef CNN_ARB_PERF_EN
  ,
  output logic [31:0]       perf_host_gnt,
  output logic [31:0]       perf_eng_gnt,
  output logic [31:0]       perf_host_stall
`endif
);

  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);

  typedef enum logic {PTR_HOST = 1'b0, PTR_ENG = 1'b1} ptr_t;

  ptr_t          ptr_q, ptr_d;
  logic          prev_eng_q, prev_eng_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;

  logic              host_req;
  logic              gnt_h, gnt_e, any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              oor;

  logic rd1_vld, rd1_host, rd1_oor;

  assign host_req = h_chipselect & (h_read | h_write);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q      <= PTR_HOST;
      prev_eng_q <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      prev_eng_q <= prev_eng_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Lock is honoured only while the engine owns the previous grant, and only
  // until the host has watched LOCK_MAX engine grants go by.
  always_comb begin
    gnt_h      = 1'b0;
    gnt_e      = 1'b0;
    ptr_d      = ptr_q;
    prev_eng_d = prev_eng_q;
    lock_cnt_d = lock_cnt_q;
    if (reset) begin
      if (host_req && e_req) begin
        if (lock_cnt_q == LW'(LOCK_MAX))  gnt_h = 1'b1;
        else if (e_lock && prev_eng_q)    gnt_e = 1'b1;
        else if (ptr_q == PTR_HOST)       gnt_h = 1'b1;
        else                              gnt_e = 1'b1;
      end else if (host_req) begin
        gnt_h = 1'b1;
      end else if (e_req) begin
        gnt_e = 1'b1;
      end
      if (gnt_h) begin
        ptr_d      = PTR_ENG;
        prev_eng_d = 1'b0;
      end else if (gnt_e) begin
        ptr_d      = PTR_HOST;
        prev_eng_d = 1'b1;
      end
      if (!host_req || gnt_h) lock_cnt_d = '0;
      else if (gnt_e)         lock_cnt_d = lock_cnt_q + LW'(1);
    end
  end

  assign any_gnt   = gnt_h | gnt_e;
  assign sel_addr  = gnt_h ? h_address : e_addr;
  assign sel_wdata = gnt_h ? h_writedata : e_wdata;
  assign sel_we    = gnt_h ? h_write : e_we;
  assign oor       = any_gnt & (32'(sel_addr) >= DEPTH_U);

  assign m_chipselect  = any_gnt & ~oor;
  assign m_read        = m_chipselect & ~sel_we;
  assign m_write       = m_chipselect & sel_we;
  assign m_address     = m_chipselect ? sel_addr : '0;
  assign m_writedata   = m_write ? sel_wdata : '0;
  assign h_waitrequest = ~reset | (host_req & ~gnt_h);
  assign e_gnt         = gnt_e;

  // Stage 1 carries the owner tag alongside the memory's registered read;
  // stage 2 captures the data and raises the owner's valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd1_vld         <= 1'b0;
      rd1_host        <= 1'b0;
      rd1_oor         <= 1'b0;
      h_readdatavalid <= 1'b0;
      h_readdata      <= '0;
      e_rvalid        <= 1'b0;
      e_rdata         <= '0;
      err_oor         <= 1'b0;
    end else begin
      rd1_vld         <= any_gnt & ~sel_we;
      rd1_host        <= gnt_h;
      rd1_oor         <= oor;
      h_readdatavalid <= rd1_vld & rd1_host;
      e_rvalid        <= rd1_vld & ~rd1_host;
      if (rd1_vld && rd1_host)  h_readdata <= rd1_oor ? '0 : m_readdata;
      if (rd1_vld && !rd1_host) e_rdata    <= rd1_oor ? '0 : m_readdata;
      if (oor) err_oor <= 1'b1;
    end
  end

`ifdef CNN_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_host_gnt   <= '0;
      perf_eng_gnt    <= '0;
      perf_host_stall <= '0;
    end else begin
      if (gnt_h && perf_host_gnt != '1) perf_host_gnt <= perf_host_gnt + 32'd1;
      if (gnt_e && perf_eng_gnt != '1)  perf_eng_gnt  <= perf_eng_gnt + 32'd1;
      if (host_req && !gnt_h && perf_host_stall != '1)
        perf_host_stall <= perf_host_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cnn_mem_arb.sv
// tb/tb_cnn_mem_arb.sv - randomized and directed bench for cnn_mem_arb against a rule-level model
module tb_cnn_mem_arb;
  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DEPTH = 375000;
  localparam int LMAX  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          h_chipselect, h_read, h_write;
  logic [AW-1:0] h_address;
  logic [DW-1:0] h_writedata;
  logic          h_waitrequest, h_readdatavalid;
  logic [DW-1:0] h_readdata;
  logic          e_req, e_we, e_lock;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          e_gnt, e_rvalid;
  logic [DW-1:0] e_rdata;
  logic          err_oor;
  logic          m_chipselect, m_read, m_write;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_writedata;
  logic [DW-1:0] m_readdata = '0;
`ifdef CNN_ARB_PERF_EN
  logic [31:0] perf_host_gnt, perf_eng_gnt, perf_host_stall;
`endif

  cnn_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .reset(reset),
    .h_chipselect(h_chipselect), .h_read(h_read), .h_write(h_write),
    .h_address(h_address), .h_writedata(h_writedata),
    .h_waitrequest(h_waitrequest), .h_readdatavalid(h_readdatavalid), .h_readdata(h_readdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata), .e_lock(e_lock),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .err_oor(err_oor),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata)
`ifdef CNN_ARB_PERF_EN
    , .perf_host_gnt(perf_host_gnt), .perf_eng_gnt(perf_eng_gnt), .perf_host_stall(perf_host_stall)
`endif
  );

  // Memory with a registered read port
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (m_chipselect) begin
      if (m_write)     mem[m_address] <= m_writedata;
      else if (m_read) m_readdata     <= mem[m_address];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Model state: who won last (0 none, 1 host, 2 engine), engine wins while host waited
  int            last_win = 0;
  int            streak   = 0;
  bit            s1_vld = 0, s1_host = 0;
  logic [DW-1:0] s1_data = '0;
  bit            x_hv = 0, x_ev = 0, x_err = 0;
  logic [DW-1:0] x_hd = '0, x_ed = '0;
  bit            chk_reg = 0;
  bit            h_pending = 0;

  task automatic tick();
    int            win;
    bit            hreq, ereq, we, oor;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    @(negedge clk);
    hreq = reset && h_chipselect && (h_read || h_write);
    ereq = reset && e_req;
    win  = 0;
    if (hreq && ereq) begin
      if (streak >= LMAX)                 win = 1;
      else if (e_lock && last_win == 2)   win = 2;
      else                                win = (last_win == 1) ? 2 : 1;
    end else if (hreq) win = 1;
    else if (ereq)     win = 2;
    a   = (win == 1) ? h_address : e_addr;
    we  = (win == 1) ? h_write : e_we;
    wd  = (win == 1) ? h_writedata : e_wdata;
    oor = (win != 0) && (int'(a) >= DEPTH);

    check("h_waitrequest", 32'(h_waitrequest), 32'(!reset || (hreq && win != 1)));
    check("e_gnt", 32'(e_gnt), 32'(win == 2));
    check("m_chipselect", 32'(m_chipselect), 32'(win != 0 && !oor));
    check("m_read", 32'(m_read), 32'(win != 0 && !oor && !we));
    check("m_write", 32'(m_write), 32'(win != 0 && !oor && we));
    if (win != 0 && !oor) begin
      check("m_address", 32'(m_address), 32'(a));
      if (we) check("m_writedata", 32'(m_writedata), 32'(wd));
    end
    if (chk_reg) begin
      check("h_readdatavalid", 32'(h_readdatavalid), 32'(x_hv));
      check("e_rvalid", 32'(e_rvalid), 32'(x_ev));
      check("h_readdata", 32'(h_readdata), 32'(x_hd));
      check("e_rdata", 32'(e_rdata), 32'(x_ed));
      check("err_oor", 32'(err_oor), 32'(x_err));
    end

    if (!reset) begin
      last_win = 0; streak = 0; s1_vld = 0; s1_host = 0;
      x_hv = 0; x_ev = 0; x_hd = '0; x_ed = '0; x_err = 0;
      chk_reg = 1;
    end else begin
      x_hv = s1_vld && s1_host;
      x_ev = s1_vld && !s1_host;
      if (x_hv) x_hd = s1_data;
      if (x_ev) x_ed = s1_data;
      s1_vld  = (win != 0) && !we;
      s1_host = (win == 1);
      s1_data = oor ? '0 : ref_mem[a];
      if (win != 0 && we && !oor) ref_mem[a] = wd;
      if (oor) x_err = 1;
      if (win != 0) last_win = win;
      if (!hreq || win == 1) streak = 0;
      else if (win == 2)     streak++;
    end
    h_pending = hreq && (win != 1);
    @(posedge clk);
    #1;
  endtask

  task automatic host_idle();
    h_chipselect = 0; h_read = 0; h_write = 0; h_address = '0; h_writedata = '0;
  endtask
  task automatic host_rd(input logic [AW-1:0] a);
    h_chipselect = 1; h_read = 1; h_write = 0; h_address = a;
  endtask
  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    h_chipselect = 1; h_read = 0; h_write = 1; h_address = a; h_writedata = d;
  endtask
  task automatic eng_idle();
    e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_lock = 0;
  endtask
  task automatic eng_rd(input logic [AW-1:0] a);
    e_req = 1; e_we = 0; e_addr = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) < 8) return AW'($urandom_range(0, 63));
    return AW'(DEPTH - 3 + int'($urandom_range(0, 5)));
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = DEPTH - 8; i < DEPTH; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 10; i < 13; i++) begin
      mem[i] = 8'(16 + i - 10);
      ref_mem[i] = mem[i];
    end

    reset = 0; host_rd(3); eng_idle();
    tick(); tick(); tick();
    reset = 1; host_idle();
    tick();

    // Host write then read back
    host_wr(19'h00005, 8'hA5); tick();
    host_rd(19'h00005); tick();
    host_idle(); tick(); tick();

    // Both requesting, no lock: strict alternation
    for (int i = 0; i < 8; i++) begin
      host_rd(AW'($urandom_range(0, 63)));
      eng_rd(AW'($urandom_range(0, 63)));
      tick();
    end
    host_idle(); eng_idle(); tick(); tick();

    // Locked engine burst against a waiting host
    e_lock = 1;
    for (int i = 0; i < 14; i++) begin
      host_rd(AW'(20 + i));
      eng_rd(AW'(40 + i));
      tick();
    end
    host_idle(); eng_idle(); tick(); tick();

    // Out-of-range read, then legal traffic with the flag held
    host_rd(AW'(DEPTH)); tick();
    host_idle(); tick(); tick();
    host_wr(7, 8'h3C); tick();
    host_rd(7); tick();
    host_idle(); tick(); tick();

    // Reset one cycle after an engine read grant
    eng_rd(33); tick();
    eng_idle(); host_rd(2); reset = 0; tick();
    reset = 1; tick(); host_idle(); tick(); tick();

    // Back-to-back mixed reads
    eng_rd(10); tick();
    eng_idle(); host_rd(11); tick();
    host_idle(); eng_rd(12); tick();
    eng_idle(); tick(); tick(); tick();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      if (!h_pending) begin
        if ($urandom_range(0, 3) == 0) host_idle();
        else if ($urandom_range(0, 2) == 0) host_wr(rand_addr(), 8'($urandom));
        else begin
          host_rd(rand_addr());
          h_write = ($urandom_range(0, 7) == 0);
          h_writedata = 8'($urandom);
        end
      end
      e_req   = ($urandom_range(0, 3) != 0);
      e_we    = ($urandom_range(0, 2) == 0);
      e_addr  = rand_addr();
      e_wdata = 8'($urandom);
      e_lock  = ($urandom_range(0, 1) == 1);
      reset   = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset = 1; host_idle(); eng_idle(); tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
